merge_rr_pipe: RTL and testbench
================================

MERGE_RR_PIPE -- requirements
Module: merge_rr_pipe

Interface
REQ-001 SHALL have parameter p_nbits, default 32, giving the message width of every input and the output.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port in_val, input, 4 bits: bit i set means in_msg<i> is valid.
REQ-005 SHALL have port in_rdy, output, 4 bits: bit i set means input i is accepted this cycle.
REQ-006 SHALL have ports in_msg0..in_msg3, input, p_nbits each: candidate messages.
REQ-007 SHALL have port out_val, output, 1 bit: the output register holds a valid message.
REQ-008 SHALL have port out_rdy, input, 1 bit: the consumer accepts out_msg this cycle.
REQ-009 SHALL have port out_msg, output, p_nbits: the registered winning message.
REQ-010 SHALL have port out_src, output, 2 bits: the index of the input that produced out_msg.

Function
REQ-011 SHALL be a 4:1 val/rdy merge: a round-robin arbiter drives the select of a 4-input mux, followed by a one-entry output register.
REQ-012 SHALL transfer on an input when in_val[i] && in_rdy[i], and on the output when out_val && out_rdy.
REQ-013 SHALL implement two states: EMPTY (out_val=0) and FULL (out_val=1).
REQ-014 SHALL compute can_accept = EMPTY || (FULL && out_rdy), so a drain and a fill in the same cycle sustain one message per cycle.
REQ-015 SHALL grant exactly one input when can_accept and any in_val bit is set; the grant goes to the first valid index searched upward from the priority pointer, wrapping 3->0.
REQ-016 SHALL assert in_rdy[i] only for the granted input and only when can_accept; all other in_rdy bits are 0 in that cycle.
REQ-017 SHALL make in_rdy depend combinationally on in_val, out_rdy and state, and SHALL NOT make it depend on in_msg.
REQ-018 SHALL, on an accepted input i, register in_msg<i> into out_msg and i into out_src, and go to FULL at the next edge.
REQ-019 SHALL have a latency of 1 cycle from input transfer to out_val.
REQ-020 SHALL, on an accepted input i, set the priority pointer to (i+1) mod 4; the pointer is unchanged in cycles with no grant.
REQ-021 SHALL go FULL->EMPTY when the output drains and no input is accepted in the same cycle.
REQ-022 SHALL stay FULL with out_msg and out_src held stable while out_val && !out_rdy.
REQ-023 SHALL keep all in_rdy bits at 0 when FULL && !out_rdy, regardless of in_val.
REQ-024 SHALL keep out_msg and out_src unchanged in EMPTY when there is no grant.
REQ-025 SHALL neither drop nor duplicate a message; every accepted input appears on the output exactly once.

Reset
REQ-026 SHALL, while reset=0 (asynchronously on assertion), force out_val=0, out_msg=0, out_src=0, the priority pointer to 0 and the state to EMPTY.
REQ-027 SHALL drive in_rdy=4'b0000 while reset=0.
REQ-028 SHALL discard any message held when reset asserts mid-operation; no transfer completes in that cycle.
REQ-029 SHALL allow the first grant in the first cycle after reset deasserts, with pointer 0 (input 0 highest priority).

Verification
REQ-030 SHALL be verified with this scenario: after reset, in_val=4'b0001, in_msg0=0x11, out_rdy=1 -> in_rdy=4'b0001; the next cycle out_val=1, out_msg=0x11, out_src=0.
REQ-031 SHALL be verified with this scenario: in_val=4'b1111 held with out_rdy=1 -> grants go 0,1,2,3,0 on consecutive cycles and out_src follows one cycle later.
REQ-032 SHALL be verified with this scenario: FULL with out_msg=0x22, out_rdy=0 for 3 cycles, in_val=4'b0100 -> in_rdy=0 and out_msg stays 0x22; when out_rdy=1, input 2 is accepted the same cycle and out_msg=in_msg2 next cycle.
REQ-033 SHALL be verified with this scenario: pointer=3, in_val=4'b0011 -> input 0 is granted (wrap-around), and the pointer becomes 1.
REQ-034 SHALL be verified with this scenario: reset=0 asserted mid-cycle while FULL -> out_val=0 and out_msg=0 immediately, without waiting for a clock edge; after release, input 0 has priority.
REQ-035 SHALL be verified with this scenario: random in_val and out_rdy over 10000 cycles -> a scoreboard sees every accepted (src,msg) pair in order exactly once, with no lost or duplicated message.

Source files
------------

// File: rtl/merge_rr_pipe.sv
// 4:1 val/rdy merge: a round-robin arbiter selects one valid input into a
// one-entry output register. A drain and a refill can happen in the same cycle.
module merge_rr_pipe #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         in_val,
    output logic [3:0]         in_rdy,
    input  logic [p_nbits-1:0] in_msg0,
    input  logic [p_nbits-1:0] in_msg1,
    input  logic [p_nbits-1:0] in_msg2,
    input  logic [p_nbits-1:0] in_msg3,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic [1:0]         out_src
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [p_nbits-1:0] msg_q, msg_d;
    logic [1:0]         src_q, src_d;

    logic               can_accept;
    logic               gnt_any;
    logic [1:0]         gnt_idx;
    logic               accept;
    logic [p_nbits-1:0] sel_msg;

    // Search downward in offset so the smallest offset from the pointer wins.
    always_comb begin
        logic [1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        idx     = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (in_val[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        sel_msg = in_msg0;
        case (gnt_idx)
            2'd0: sel_msg = in_msg0;
            2'd1: sel_msg = in_msg1;
            2'd2: sel_msg = in_msg2;
            2'd3: sel_msg = in_msg3;
            default: sel_msg = in_msg0;
        endcase
    end

    // in_rdy is gated by reset so nothing is offered while the block is held.
    assign can_accept = (state_q == EMPTY) || out_rdy;
    assign accept     = can_accept && gnt_any && reset;
    assign in_rdy     = accept ? (4'b0001 << gnt_idx) : 4'b0000;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        msg_d   = msg_q;
        src_d   = src_q;
        if (accept) begin
            state_d = FULL;
            msg_d   = sel_msg;
            src_d   = gnt_idx;
            ptr_d   = gnt_idx + 2'd1;
        end else if (state_q == FULL && out_rdy) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            ptr_q   <= 2'd0;
            msg_q   <= '0;
            src_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            msg_q   <= msg_d;
            src_q   <= src_d;
        end
    end

    assign out_val = (state_q == FULL);
    assign out_msg = msg_q;
    assign out_src = src_q;

endmodule

// File: tb/tb_merge_rr_pipe.sv
// Directed and randomized checks for merge_rr_pipe: arbitration order,
// backpressure, wrap-around, async reset and an in-order scoreboard.
module tb_merge_rr_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_val;
    logic [3:0]   in_rdy;
    logic [W-1:0] in_msg0, in_msg1, in_msg2, in_msg3;
    logic         out_val;
    logic         out_rdy;
    logic [W-1:0] out_msg;
    logic [1:0]   out_src;

    int nchk = 0;
    int nerr = 0;

    merge_rr_pipe #(.p_nbits(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_msg0 (in_msg0),
        .in_msg1 (in_msg1),
        .in_msg2 (in_msg2),
        .in_msg3 (in_msg3),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg),
        .out_src (out_src)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        in_val = 4'b0000;
        out_rdy = 1'b0;
        in_msg0 = '0; in_msg1 = '0; in_msg2 = '0; in_msg3 = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        in_val = 4'b1111;
        out_rdy = 1'b1;
        in_msg0 = 32'h5; in_msg1 = 32'h6; in_msg2 = 32'h7; in_msg3 = 32'h8;
        tick();
        tick();
        nchk++; if (out_val !== 1'b0) begin nerr++; $display("FAIL reset_out_val got %b exp 0", out_val); end
        nchk++; if (out_msg !== '0) begin nerr++; $display("FAIL reset_out_msg got %h exp 0", out_msg); end
        nchk++; if (out_src !== 2'd0) begin nerr++; $display("FAIL reset_out_src got %0d exp 0", out_src); end
        nchk++; if (in_rdy !== 4'b0000) begin nerr++; $display("FAIL reset_in_rdy got %b exp 0000", in_rdy); end
    endtask

    task automatic test_single();
        do_reset();
        in_val = 4'b0001; in_msg0 = 32'h11; out_rdy = 1'b1;
        #1;
        nchk++; if (in_rdy !== 4'b0001) begin nerr++; $display("FAIL single_in_rdy got %b exp 0001", in_rdy); end
        tick();
        in_val = 4'b0000;
        nchk++; if (out_val !== 1'b1) begin nerr++; $display("FAIL single_out_val got %b exp 1", out_val); end
        nchk++; if (out_msg !== 32'h11) begin nerr++; $display("FAIL single_out_msg got %h exp 11", out_msg); end
        nchk++; if (out_src !== 2'd0) begin nerr++; $display("FAIL single_out_src got %0d exp 0", out_src); end
        tick();
        nchk++; if (out_val !== 1'b0) begin nerr++; $display("FAIL single_drain got %b exp 0", out_val); end
    endtask

    task automatic test_round_robin();
        logic [1:0] seq [5];
        logic [3:0] exp_rdy;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0;
        do_reset();
        in_msg0 = 32'hA0; in_msg1 = 32'hA1; in_msg2 = 32'hA2; in_msg3 = 32'hA3;
        in_val = 4'b1111; out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp_rdy = 4'b0001 << seq[i];
            nchk++; if (in_rdy !== exp_rdy) begin nerr++; $display("FAIL rr_in_rdy[%0d] got %b exp %b", i, in_rdy, exp_rdy); end
            tick();
            nchk++; if (out_src !== seq[i] || out_val !== 1'b1) begin
                nerr++; $display("FAIL rr_out_src[%0d] got %0d/%b exp %0d/1", i, out_src, out_val, seq[i]);
            end
            nchk++; if (out_msg !== 32'hA0 + 32'(seq[i])) begin nerr++; $display("FAIL rr_out_msg[%0d] got %h exp %h", i, out_msg, 32'hA0 + 32'(seq[i])); end
        end
        in_val = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_val = 4'b0010; in_msg1 = 32'h22; out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0; in_val = 4'b0100; in_msg2 = 32'h33;
        for (int i = 0; i < 3; i++) begin
            #1;
            nchk++; if (in_rdy !== 4'b0000) begin nerr++; $display("FAIL bp_in_rdy[%0d] got %b exp 0000", i, in_rdy); end
            tick();
            nchk++; if (out_val !== 1'b1 || out_msg !== 32'h22 || out_src !== 2'd1) begin
                nerr++; $display("FAIL bp_hold[%0d] got %b/%h/%0d exp 1/22/1", i, out_val, out_msg, out_src);
            end
        end
        out_rdy = 1'b1;
        #1;
        nchk++; if (in_rdy !== 4'b0100) begin nerr++; $display("FAIL bp_release_rdy got %b exp 0100", in_rdy); end
        tick();
        in_val = 4'b0000;
        nchk++; if (out_val !== 1'b1 || out_msg !== 32'h33 || out_src !== 2'd2) begin
            nerr++; $display("FAIL bp_refill got %b/%h/%0d exp 1/33/2", out_val, out_msg, out_src);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        out_rdy = 1'b1;
        in_val = 4'b0100; in_msg2 = 32'h2;
        tick();
        in_val = 4'b0011; in_msg0 = 32'h40; in_msg1 = 32'h41;
        #1;
        nchk++; if (in_rdy !== 4'b0001) begin nerr++; $display("FAIL wrap_grant got %b exp 0001", in_rdy); end
        tick();
        nchk++; if (out_src !== 2'd0 || out_msg !== 32'h40) begin nerr++; $display("FAIL wrap_out got %0d/%h exp 0/40", out_src, out_msg); end
        #1;
        nchk++; if (in_rdy !== 4'b0010) begin nerr++; $display("FAIL wrap_ptr1 got %b exp 0010", in_rdy); end
        tick();
        in_val = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_rdy = 1'b0;
        in_val = 4'b0010; in_msg1 = 32'h44;
        tick();
        in_val = 4'b1111;
        #2;
        reset = 1'b0;
        #1;
        nchk++; if (out_val !== 1'b0 || out_msg !== '0 || out_src !== 2'd0) begin
            nerr++; $display("FAIL midreset_async got %b/%h/%0d exp 0/0/0", out_val, out_msg, out_src);
        end
        nchk++; if (in_rdy !== 4'b0000) begin nerr++; $display("FAIL midreset_in_rdy got %b exp 0000", in_rdy); end
        reset = 1'b1;
        in_val = 4'b0110;
        #1;
        nchk++; if (in_rdy !== 4'b0010) begin nerr++; $display("FAIL midreset_priority got %b exp 0010", in_rdy); end
        tick();
        in_val = 4'b0000; out_rdy = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [W+1:0] q [$];
        logic [W+1:0] front;
        logic [W-1:0] m [4];
        logic [3:0]   exp_rdy;
        int           mptr;
        int           idx;
        int           sel;
        int           prints;
        bit           can;
        mptr = 0; prints = 0;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            for (int j = 0; j < 4; j++) m[j] = $urandom;
            in_msg0 = m[0]; in_msg1 = m[1]; in_msg2 = m[2]; in_msg3 = m[3];
            in_val  = 4'($urandom_range(0, 15));
            out_rdy = ($urandom_range(0, 3) != 0);
            #1;
            can = (q.size() == 0) || out_rdy;
            exp_rdy = 4'b0000; sel = -1;
            if (can) begin
                for (int k = 0; k < 4; k++) begin
                    idx = (mptr + k) % 4;
                    if (sel < 0 && in_val[idx]) sel = idx;
                end
                if (sel >= 0) exp_rdy = 4'b0001 << sel;
            end
            nchk++; if (in_rdy !== exp_rdy) begin
                nerr++; if (prints++ < 10) $display("FAIL rand_in_rdy c=%0d got %b exp %b", c, in_rdy, exp_rdy);
            end
            nchk++; if (out_val !== (q.size() != 0)) begin
                nerr++; if (prints++ < 10) $display("FAIL rand_out_val c=%0d got %b exp %b", c, out_val, q.size() != 0);
            end
            if (out_val && out_rdy && q.size() > 0) begin
                front = q.pop_front();
                nchk++; if ({out_src, out_msg} !== front) begin
                    nerr++; if (prints++ < 10) $display("FAIL rand_scoreboard c=%0d got %0d/%h exp %0d/%h", c, out_src, out_msg, front[W+1:W], front[W-1:0]);
                end
            end
            if (sel >= 0) begin
                q.push_back({2'(sel), m[sel]});
                mptr = (sel + 1) % 4;
            end
            tick();
        end
        in_val = 4'b0000; out_rdy = 1'b1;
        #1;
        if (out_val && q.size() > 0) begin
            front = q.pop_front();
            nchk++; if ({out_src, out_msg} !== front) begin nerr++; $display("FAIL rand_final got %0d/%h exp %0d/%h", out_src, out_msg, front[W+1:W], front[W-1:0]); end
        end
        tick();
        nchk++; if (out_val !== 1'b0 || q.size() != 0) begin nerr++; $display("FAIL rand_drain got out_val=%b pending=%0d exp 0/0", out_val, q.size()); end
    endtask

    initial begin
        reset = 1'b0; in_val = 4'b0000; out_rdy = 1'b0;
        in_msg0 = '0; in_msg1 = '0; in_msg2 = '0; in_msg3 = '0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
